// File: rtl/fixed_set_pkg.sv
// Shared definitions for the fixed-value bank:
//   state_t     - commit FSM states (IDLE, COMMIT)
//   DEFAULT_CH  - default number of init/step channels
//   DEFAULT_DW  - default width of each init/step value
package fixed_set_pkg;

   localparam int DEFAULT_CH = 4;
   localparam int DEFAULT_DW = 8;

   typedef enum logic {
      IDLE   = 1'b0,
      COMMIT = 1'b1
   } state_t;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchroniser with a registered rising-edge pulse.
// Ports:
//   clk    - sole clock
//   reset  - synchronous active-high reset
//   din    - asynchronous level input
//   rise   - one-cycle pulse, registered, following a low-to-high change of din
module edge_sync (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic rise
);

   logic f0;
   logic f1;

   // f0/f1 form the synchroniser chain; the pulse is registered so that the
   // capture logic downstream sees a clean, glitch-free single-cycle strobe.
   always_ff @(posedge clk) begin
      if (reset) begin
         f0   <= 1'b0;
         f1   <= 1'b0;
         rise <= 1'b0;
      end else begin
         f0   <= din;
         f1   <= f0;
         rise <= f0 & ~f1;
      end
   end

endmodule

// File: rtl/fixed_set_bank.sv
// Double-buffered bank of per-channel init/step values.
// A rising edge on update_flag captures one channel into its shadow register;
// apply commits every pending shadow channel into the active registers.
// Ports:
//   clk, reset      - clock and synchronous active-high reset
//   update_flag     - level request, its rising edge captures one channel
//   ch_sel          - channel targeted by the capture
//   fixed_init      - init value to capture
//   fixed_step      - step value to capture (zero is rejected)
//   apply           - commit request, shadow to active for pending channels
//   clr_err         - clears err_sticky
//   fixed_init_out  - active init values, channel n at [n*DW +: DW]
//   fixed_step_out  - active step values, same packing
//   pending         - per-channel flag, shadow holds uncommitted data
//   busy            - commit in progress or queued
//   commit_done     - one-cycle pulse after a commit
//   err_sticky      - set by any rejected capture
module fixed_set_bank
   import fixed_set_pkg::*;
#(
   parameter int CH = DEFAULT_CH,
   parameter int DW = DEFAULT_DW,
   parameter int SW = (CH == 1) ? 1 : $clog2(CH)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            update_flag,
   input  logic [SW-1:0]   ch_sel,
   input  logic [DW-1:0]   fixed_init,
   input  logic [DW-1:0]   fixed_step,
   input  logic            apply,
   input  logic            clr_err,
   output logic [CH*DW-1:0] fixed_init_out,
   output logic [CH*DW-1:0] fixed_step_out,
   output logic [CH-1:0]   pending,
   output logic            busy,
   output logic            commit_done,
   output logic            err_sticky
);

   localparam logic [SW:0] CH_LIMIT = (SW+1)'(CH);

   state_t          state;
   logic            apply_q;
   logic            rise;
   logic            sel_valid;
   logic            cap_rej;
   logic [CH-1:0]   cap_mask;
   logic [DW-1:0]   shadow_init [CH];
   logic [DW-1:0]   shadow_step [CH];
   logic [DW-1:0]   active_init [CH];
   logic [DW-1:0]   active_step [CH];

   edge_sync u_update_sync (
      .clk   (clk),
      .reset (reset),
      .din   (update_flag),
      .rise  (rise)
   );

   // Decode the capture request: ch_sel may be wider than needed, so
   // out-of-range channels and a zero step turn the capture into a rejection.
   always_comb begin
      sel_valid = ({1'b0, ch_sel} < CH_LIMIT);
      cap_rej   = rise && !(sel_valid && (fixed_step != '0));
      cap_mask  = '0;
      for (int n = 0; n < CH; n++) begin
         if (rise && sel_valid && (fixed_step != '0) && (ch_sel == SW'(n))) begin
            cap_mask[n] = 1'b1;
         end
      end
   end

   // Capture, error tracking and the commit FSM. A capture landing on the
   // commit edge writes shadow while the commit copies the old shadow, and
   // the captured channel stays pending.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         apply_q     <= 1'b0;
         pending     <= '0;
         commit_done <= 1'b0;
         err_sticky  <= 1'b0;
         for (int n = 0; n < CH; n++) begin
            shadow_init[n] <= '0;
            shadow_step[n] <= '0;
            active_init[n] <= '0;
            active_step[n] <= '0;
         end
      end else begin
         commit_done <= 1'b0;

         for (int n = 0; n < CH; n++) begin
            if (cap_mask[n]) begin
               shadow_init[n] <= fixed_init;
               shadow_step[n] <= fixed_step;
            end
         end

         if (cap_rej) begin
            err_sticky <= 1'b1;
         end else if (clr_err) begin
            err_sticky <= 1'b0;
         end

         case (state)
            IDLE: begin
               pending <= pending | cap_mask;
               if (apply || apply_q) begin
                  apply_q <= 1'b0;
                  if (pending != '0) begin
                     state <= COMMIT;
                  end
               end
            end
            COMMIT: begin
               for (int n = 0; n < CH; n++) begin
                  if (pending[n]) begin
                     active_init[n] <= shadow_init[n];
                     active_step[n] <= shadow_step[n];
                  end
               end
               pending     <= cap_mask;
               commit_done <= 1'b1;
               state       <= IDLE;
               if (apply) begin
                  apply_q <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Pack the active registers onto the flat output buses.
   always_comb begin
      fixed_init_out = '0;
      fixed_step_out = '0;
      for (int n = 0; n < CH; n++) begin
         fixed_init_out[n*DW +: DW] = active_init[n];
         fixed_step_out[n*DW +: DW] = active_step[n];
      end
   end

   assign busy = (state == COMMIT) || apply_q;

endmodule

// File: tb/tb_fixed_set_bank.sv
// Self-checking bench for fixed_set_bank (CH=4, DW=8, ch_sel widened to 3 bits
// so out-of-range channels can be requested).
module tb_fixed_set_bank;

   logic        clk;
   logic        reset;
   logic        update_flag;
   logic [2:0]  ch_sel;
   logic [7:0]  fixed_init;
   logic [7:0]  fixed_step;
   logic        apply;
   logic        clr_err;
   logic [31:0] fixed_init_out;
   logic [31:0] fixed_step_out;
   logic [3:0]  pending;
   logic        busy;
   logic        commit_done;
   logic        err_sticky;

   int checks = 0;
   int passes = 0;
   int done_cnt = 0;
   int d0;

   fixed_set_bank #(.CH(4), .DW(8), .SW(3)) dut (
      .clk            (clk),
      .reset          (reset),
      .update_flag    (update_flag),
      .ch_sel         (ch_sel),
      .fixed_init     (fixed_init),
      .fixed_step     (fixed_step),
      .apply          (apply),
      .clr_err        (clr_err),
      .fixed_init_out (fixed_init_out),
      .fixed_step_out (fixed_step_out),
      .pending        (pending),
      .busy           (busy),
      .commit_done    (commit_done),
      .err_sticky     (err_sticky)
   );

   // 10-time-unit clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: a capture happens two edges after update_flag is first
   // seen high after having been low; a commit occupies the cycle after an
   // accepted apply and copies every pending shadow channel at its end.
   logic [7:0] m_si [4];
   logic [7:0] m_ss [4];
   logic [7:0] m_ai [4];
   logic [7:0] m_as [4];
   logic [3:0] m_pend;
   logic       m_err, m_commit, m_aq, m_done, m_valid;
   logic       h1, h2, h3;
   logic       m_cap, m_rej;
   logic [3:0] m_capm;

   initial m_valid = 1'b0;

   always @(posedge clk) begin
      if (reset) begin
         for (int n = 0; n < 4; n++) begin
            m_si[n] = 8'h00; m_ss[n] = 8'h00; m_ai[n] = 8'h00; m_as[n] = 8'h00;
         end
         m_pend = 4'b0000; m_err = 1'b0; m_commit = 1'b0; m_aq = 1'b0; m_done = 1'b0;
         h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
         m_valid = 1'b1;
      end else if (m_valid) begin
         m_cap  = h2 & ~h3;
         m_capm = 4'b0000;
         m_rej  = 1'b0;
         if (m_cap) begin
            if (ch_sel < 3'd4 && fixed_step != 8'h00) m_capm[ch_sel[1:0]] = 1'b1;
            else m_rej = 1'b1;
         end
         if (m_commit) begin
            for (int n = 0; n < 4; n++) begin
               if (m_pend[n]) begin
                  m_ai[n] = m_si[n];
                  m_as[n] = m_ss[n];
               end
            end
            m_pend   = 4'b0000;
            m_done   = 1'b1;
            m_commit = 1'b0;
            if (apply) m_aq = 1'b1;
         end else begin
            m_done = 1'b0;
            if (apply || m_aq) begin
               m_aq = 1'b0;
               if (m_pend != 4'b0000) m_commit = 1'b1;
            end
         end
         if (m_capm != 4'b0000) begin
            m_si[ch_sel[1:0]] = fixed_init;
            m_ss[ch_sel[1:0]] = fixed_step;
            m_pend = m_pend | m_capm;
         end
         if (m_rej) m_err = 1'b1;
         else if (clr_err) m_err = 1'b0;
         h3 = h2; h2 = h1; h1 = update_flag;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual === expected) passes++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
   endtask

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (m_valid) begin
         checkOutput("init_out", fixed_init_out, {m_ai[3], m_ai[2], m_ai[1], m_ai[0]});
         checkOutput("step_out", fixed_step_out, {m_as[3], m_as[2], m_as[1], m_as[0]});
         checkOutput("pending", {28'd0, pending}, {28'd0, m_pend});
         checkOutput("busy", {31'd0, busy}, {31'd0, (m_commit | m_aq)});
         checkOutput("commit_done", {31'd0, commit_done}, {31'd0, m_done});
         checkOutput("err_sticky", {31'd0, err_sticky}, {31'd0, m_err});
         if (commit_done === 1'b1) done_cnt++;
      end
   end

   task automatic waitCycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic applyStimulus(input logic [2:0] sel, input logic [7:0] init, input logic [7:0] step);
      ch_sel      = sel;
      fixed_init  = init;
      fixed_step  = step;
      update_flag = 1'b1;
      waitCycles(3);
      update_flag = 1'b0;
      waitCycles(3);
   endtask

   task automatic pulseApply();
      apply = 1'b1;
      waitCycles(1);
      apply = 1'b0;
      waitCycles(2);
   endtask

   initial begin
      reset = 1'b1; update_flag = 1'b0; ch_sel = 3'd0; fixed_init = 8'h00;
      fixed_step = 8'h00; apply = 1'b0; clr_err = 1'b0;
      waitCycles(3);
      reset = 1'b0;
      waitCycles(1);
      checkOutput("rst_init", fixed_init_out, 32'h0);
      checkOutput("rst_step", fixed_step_out, 32'h0);
      checkOutput("rst_pending", {28'd0, pending}, 32'h0);
      checkOutput("rst_busy", {31'd0, busy}, 32'h0);

      // single capture and commit on ch2
      applyStimulus(3'd2, 8'h10, 8'h03);
      checkOutput("cap_pending", {28'd0, pending}, 32'h4);
      checkOutput("cap_no_active", fixed_init_out, 32'h0);
      apply = 1'b1;
      waitCycles(1);
      checkOutput("commit_busy", {31'd0, busy}, 32'h1);
      apply = 1'b0;
      waitCycles(1);
      checkOutput("commit_pulse", {31'd0, commit_done}, 32'h1);
      checkOutput("commit_init", fixed_init_out, 32'h0010_0000);
      checkOutput("commit_step", fixed_step_out, 32'h0003_0000);
      checkOutput("commit_pend_clr", {28'd0, pending}, 32'h0);
      waitCycles(1);
      checkOutput("pulse_one_cycle", {31'd0, commit_done}, 32'h0);

      // rejected captures: zero step, channel out of range
      applyStimulus(3'd1, 8'h55, 8'h00);
      applyStimulus(3'd5, 8'h66, 8'h07);
      checkOutput("rej_pending", {28'd0, pending}, 32'h0);
      checkOutput("rej_err", {31'd0, err_sticky}, 32'h1);
      pulseApply();
      checkOutput("drop_no_done", {31'd0, commit_done}, 32'h0);
      checkOutput("drop_init", fixed_init_out, 32'h0010_0000);
      clr_err = 1'b1;
      waitCycles(1);
      clr_err = 1'b0;
      checkOutput("clr_err", {31'd0, err_sticky}, 32'h0);

      // held update_flag with changing data: only the rise-cycle data lands
      ch_sel = 3'd0; fixed_init = 8'h31; fixed_step = 8'h02; update_flag = 1'b1;
      waitCycles(3);
      for (int i = 0; i < 17; i++) begin
         ch_sel     = 3'(i % 4);
         fixed_init = 8'(8'h40 + i);
         fixed_step = 8'(8'h80 + i);
         waitCycles(1);
      end
      update_flag = 1'b0;
      waitCycles(3);
      checkOutput("hold_pending", {28'd0, pending}, 32'h1);
      pulseApply();
      checkOutput("hold_init", fixed_init_out, 32'h0010_0031);
      checkOutput("hold_step", fixed_step_out, 32'h0003_0002);

      // ch0 capture lands on the edge that closes the ch3 commit
      applyStimulus(3'd3, 8'h77, 8'h09);
      ch_sel = 3'd0; fixed_init = 8'h20; fixed_step = 8'h01; update_flag = 1'b1;
      waitCycles(1);
      apply = 1'b1;
      waitCycles(1);
      apply = 1'b0;
      waitCycles(1);
      checkOutput("overlap_init", fixed_init_out, 32'h7710_0031);
      checkOutput("overlap_step", fixed_step_out, 32'h0903_0002);
      checkOutput("overlap_pending", {28'd0, pending}, 32'h1);
      update_flag = 1'b0;
      waitCycles(3);
      pulseApply();
      checkOutput("ch0_init", fixed_init_out, 32'h7710_0020);
      checkOutput("ch0_step", fixed_step_out, 32'h0903_0001);

      // apply during COMMIT queues a second commit for ch1
      applyStimulus(3'd2, 8'hA0, 8'h05);
      d0 = done_cnt;
      ch_sel = 3'd1; fixed_init = 8'h11; fixed_step = 8'h0B; update_flag = 1'b1;
      waitCycles(1);
      apply = 1'b1;
      waitCycles(2);
      apply = 1'b0;
      checkOutput("queued_busy", {31'd0, busy}, 32'h1);
      waitCycles(2);
      update_flag = 1'b0;
      waitCycles(3);
      checkOutput("two_pulses", 32'(done_cnt - d0), 32'd2);
      checkOutput("queued_init", fixed_init_out, 32'h77A0_1120);
      checkOutput("queued_step", fixed_step_out, 32'h0905_0B01);

      // reset during COMMIT aborts the copy
      applyStimulus(3'd1, 8'h22, 8'h0C);
      apply = 1'b1;
      waitCycles(1);
      apply = 1'b0;
      reset = 1'b1;
      waitCycles(1);
      reset = 1'b0;
      checkOutput("abort_init", fixed_init_out, 32'h0);
      checkOutput("abort_step", fixed_step_out, 32'h0);
      checkOutput("abort_pending", {28'd0, pending}, 32'h0);
      checkOutput("abort_busy", {31'd0, busy}, 32'h0);
      waitCycles(2);
      checkOutput("abort_no_done", {31'd0, commit_done}, 32'h0);

      $display("[TB] %0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
